// File: rtl/usb_pkg.sv
// Shared USB definitions: wire PID codes, framing constants and the byte-wise CRC16 step.
package usb_pkg;

  typedef enum logic [3:0] {
    PID_OUT   = 4'b0001,
    PID_IN    = 4'b1001,
    PID_SOF   = 4'b0101,
    PID_SETUP = 4'b1101,
    PID_DATA0 = 4'b0011,
    PID_DATA1 = 4'b1011,
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010,
    PID_STALL = 4'b1110
  } pid_t;

  localparam logic [7:0]  SYNC_BYTE    = 8'h80;
  localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY_R = 16'hA001;

  // Reflected CRC16 update, data byte consumed LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ CRC16_POLY_R) : (c >> 1);
    return c;
  endfunction

  function automatic logic is_data_pid(input logic [3:0] p);
    return (p == PID_DATA0) || (p == PID_DATA1);
  endfunction

  function automatic logic is_hs_pid(input logic [3:0] p);
    return (p == PID_ACK) || (p == PID_NAK) || (p == PID_STALL);
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// USB CRC16 residue register; one byte per enabled cycle, shared by the tx and rx paths.
module usb_crc16
  import usb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  always_ff @(posedge clk) begin
    if (rst || clear) crc <= CRC16_INIT;
    else if (en)      crc <= crc16_byte(crc, data);
  end

endmodule

// File: rtl/tx_fsm.sv
// Device-side USB transmit sequencer: SYNC, PID, optional payload + CRC16, then EOP request.
module tx_fsm
  import usb_pkg::*;
#(
  parameter int MAX_PKT = 64,
  parameter int CNT_W   = 10
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       start,
  input  logic [3:0] pid,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  input  logic       data_last,
  output logic       data_ready,
  output logic [7:0] tx_byte,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       tx_eop,
  input  logic       eop_done,
  output logic       busy,
  output logic       packet_done,
  output logic       pid_err,
  output logic       abort,
  output logic       len_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_EOP
  } tx_state_t;

  tx_state_t        state, nxt;
  logic [3:0]       pid_q;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      crc;
  logic             aborted;
  logic             take, pid_bad, crc_clr, crc_en, cnt_clr, cnt_inc;
  logic             abort_set, len_set, done_set;

  usb_crc16 u_crc (
    .clk   (clk),
    .rst   (RST),
    .clear (crc_clr),
    .en    (crc_en),
    .data  (data_in),
    .crc   (crc)
  );

  always_ff @(posedge clk) begin
    if (RST) begin
      state       <= S_IDLE;
      pid_q       <= '0;
      cnt         <= '0;
      aborted     <= 1'b0;
      packet_done <= 1'b0;
      pid_err     <= 1'b0;
      abort       <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      state       <= nxt;
      packet_done <= done_set;
      pid_err     <= pid_bad;
      abort       <= abort_set;
      len_err     <= len_set;
      if (take) pid_q <= pid;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + CNT_W'(1);
      if (state == S_IDLE) aborted <= 1'b0;
      else if (abort_set)  aborted <= 1'b1;
    end
  end

  always_comb begin
    nxt        = state;
    tx_byte    = 8'h00;
    tx_valid   = 1'b0;
    tx_eop     = 1'b0;
    data_ready = 1'b0;
    take       = 1'b0;
    pid_bad    = 1'b0;
    crc_clr    = 1'b0;
    crc_en     = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    abort_set  = 1'b0;
    len_set    = 1'b0;
    done_set   = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        if (is_data_pid(pid) || is_hs_pid(pid)) begin
          take = 1'b1;
          nxt  = S_SYNC;
        end else pid_bad = 1'b1;
      end
      S_SYNC: begin
        tx_valid = 1'b1;
        tx_byte  = SYNC_BYTE;
        if (tx_ready) nxt = S_PID;
      end
      S_PID: begin
        tx_valid = 1'b1;
        tx_byte  = {~pid_q, pid_q};
        if (tx_ready) begin
          if (is_data_pid(pid_q)) begin
            crc_clr = 1'b1;
            cnt_clr = 1'b1;
            nxt     = S_DATA;
          end else nxt = S_EOP;
        end
      end
      S_DATA: begin
        tx_valid   = data_valid;
        tx_byte    = data_valid ? data_in : 8'h00;
        data_ready = tx_ready;
        if (data_valid && tx_ready) begin
          crc_en  = 1'b1;
          cnt_inc = 1'b1;
          if (data_last) nxt = S_CRC_LO;
          else if (cnt == CNT_W'(MAX_PKT - 1)) begin
            // Oversize payload is cut at MAX_PKT and still closed with a valid CRC.
            len_set = 1'b1;
            nxt     = S_CRC_LO;
          end
        end else if (!data_valid && data_last) nxt = S_CRC_LO;
        else if (!data_valid && tx_ready) begin
          abort_set = 1'b1;
          nxt       = S_EOP;
        end
      end
      S_CRC_LO: begin
        tx_valid = 1'b1;
        tx_byte  = ~crc[7:0];
        if (tx_ready) nxt = S_CRC_HI;
      end
      S_CRC_HI: begin
        tx_valid = 1'b1;
        tx_byte  = ~crc[15:8];
        if (tx_ready) nxt = S_EOP;
      end
      S_EOP: begin
        tx_eop = 1'b1;
        if (eop_done) begin
          done_set = !aborted;
          nxt      = S_IDLE;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_tx_fsm.sv
// Randomized bench for tx_fsm: per-packet expected byte stream and pulses from a behavioural model.
module tb_tx_fsm;

  localparam int MAXP = 4;

  logic       clk = 1'b0;
  logic       RST, start, data_valid, data_last, tx_ready, eop_done;
  logic [3:0] pid;
  logic [7:0] data_in;
  logic       data_ready, tx_valid, tx_eop, busy, packet_done, pid_err, abort, len_err;
  logic [7:0] tx_byte;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] pl [0:15];
  logic [3:0] vp [5] = '{4'h2, 4'hA, 4'hE, 4'h3, 4'hB};

  always #5 clk = ~clk;

  tx_fsm #(.MAX_PKT(MAXP), .CNT_W(10)) dut (
    .clk(clk), .RST(RST), .start(start), .pid(pid), .data_in(data_in),
    .data_valid(data_valid), .data_last(data_last), .data_ready(data_ready),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_eop(tx_eop),
    .eop_done(eop_done), .busy(busy), .packet_done(packet_done), .pid_err(pid_err),
    .abort(abort), .len_err(len_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bit-serial CRC16 over pl[0..k-1], LSB of each byte first.
  function automatic logic [15:0] ref_crc(input int k);
    logic [15:0] r;
    logic        fb;
    r = 16'hFFFF;
    for (int i = 0; i < k; i++)
      for (int b = 0; b < 8; b++) begin
        fb = r[0] ^ pl[i][b];
        r  = {1'b0, r[15:1]};
        if (fb) r = r ^ 16'hA001;
      end
    return r;
  endfunction

  function automatic bit ok_pid(input logic [3:0] p);
    return p inside {4'h2, 4'hA, 4'hE, 4'h3, 4'hB};
  endfunction

  // und: payload index presented as an underrun (-1 none); rmode 0 ready, 1 random, 2 toggle.
  task automatic run_pkt(input logic [3:0] p, input int n, input int und, input int rmode, input int rst_after);
    logic [7:0]  exp[$];
    logic [7:0]  got[$];
    logic [15:0] r;
    int ptr = 0, k = 0, c_ab = 0, c_le = 0, c_dn = 0, c_pe = 0, hold;
    bit ab = 0, le = 0, v_rdy = 0, v_zero = 0, v_busy = 0, v_eop = 0, seen = 0, did_rst = 0;
    exp.push_back(8'h80);
    exp.push_back({~p, p});
    if (p == 4'h3 || p == 4'hB) begin
      if (und >= 0 && und < n && und < MAXP) begin ab = 1; k = und; end
      else begin k = (n < MAXP) ? n : MAXP; le = (n > MAXP); end
      for (int i = 0; i < k; i++) exp.push_back(pl[i]);
      if (!ab) begin r = ref_crc(k); exp.push_back(~r[7:0]); exp.push_back(~r[15:8]); end
    end
    @(negedge clk);
    start = 1; pid = p; tx_ready = 0; eop_done = 0;
    for (int cyc = 0; cyc < 300 && !seen && !did_rst; cyc++) begin
      @(negedge clk);
      if (rst_after > 0 && got.size() == rst_after) begin
        RST = 1; start = 1; pid = 4'h3; tx_ready = 0;
        #1 chk("crc_hi_byte", {tx_valid, tx_byte}, {1'b1, exp[rst_after]});
        @(negedge clk);
        RST = 0; start = 0;
        #1 chk("rst_outputs", {tx_valid, tx_byte, tx_eop, busy, data_ready, packet_done, abort, len_err, pid_err}, 0);
        did_rst = 1;
      end else begin
        start    = (cyc > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        pid      = 4'($urandom);
        tx_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'(cyc % 2 == 0);
        data_in    = pl[ptr];
        data_valid = (ptr < n) && (ptr != und);
        data_last  = (n == 0) || (ptr == n - 1 && ptr != und);
        #1;
        if (cyc == 0) chk("start_latency", {tx_valid, tx_byte}, {1'b1, 8'h80});
        if (data_ready && !tx_ready) v_rdy = 1;
        if (!tx_valid && tx_byte != 0) v_zero = 1;
        if (!busy) v_busy = 1;
        c_ab += int'(abort); c_le += int'(len_err); c_dn += int'(packet_done); c_pe += int'(pid_err);
        if (tx_valid && tx_ready) got.push_back(tx_byte);
        if (data_ready && data_valid) ptr++;
        if (tx_eop) seen = 1;
      end
    end
    if (!did_rst) begin
      chk("eop_reached", seen, 1);
      hold = $urandom_range(0, 3);
      for (int h = 0; h <= hold + 3; h++) begin
        @(negedge clk);
        start = 0; tx_ready = 1'($urandom_range(0, 1));
        eop_done = (h == hold);
        #1;
        if (h <= hold && (!tx_eop || tx_valid)) v_eop = 1;
        if (h > hold && (busy || tx_eop)) v_eop = 1;
        c_ab += int'(abort); c_le += int'(len_err); c_dn += int'(packet_done); c_pe += int'(pid_err);
      end
      eop_done = 0;
      chk("eop_hold", v_eop, 0);
      chk("byte_count", got.size(), exp.size());
      chk("abort", c_ab, 32'(ab));
      chk("packet_done", c_dn, 32'(!ab));
      chk("consumed", ptr, k);
    end
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      chk($sformatf("byte%0d", i), got[i], exp[i]);
    chk("len_err", c_le, 32'(le));
    chk("pid_err_busy", c_pe, 0);
    chk("ready_gate", v_rdy, 0);
    chk("idle_byte_zero", v_zero, 0);
    chk("busy_held", v_busy, 0);
  endtask

  task automatic bad_pid(input logic [3:0] p);
    @(negedge clk);
    start = 1; pid = p;
    @(negedge clk);
    start = 0;
    #1 chk("pid_err_pulse", pid_err, 1);
    chk("pid_err_quiet", {tx_valid, busy}, 0);
    @(negedge clk);
    #1 chk("pid_err_clear", {pid_err, tx_valid, busy}, 0);
  endtask

  initial begin
    logic [3:0] p;
    RST = 1; start = 0; pid = 0; data_in = 0; data_valid = 0; data_last = 0;
    tx_ready = 0; eop_done = 0;
    repeat (3) @(negedge clk);
    #1 chk("reset_outputs", {tx_valid, tx_byte, tx_eop, busy, data_ready, packet_done, abort, len_err, pid_err}, 0);
    @(negedge clk);
    RST = 0;

    for (int i = 0; i < 16; i++) pl[i] = 8'($urandom);
    run_pkt(4'h2, 0, -1, 0, 0);
    run_pkt(4'h3, 0, -1, 0, 0);
    for (int i = 0; i < 4; i++) pl[i] = 8'(i);
    run_pkt(4'hB, 4, -1, 2, 0);
    bad_pid(4'h9);
    for (int i = 0; i < 16; i++) pl[i] = 8'($urandom);
    run_pkt(4'h3, 3, 1, 0, 0);
    run_pkt(4'h3, 6, -1, 0, 7);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 16; i++) pl[i] = 8'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        do p = 4'($urandom); while (ok_pid(p));
        bad_pid(p);
      end else begin
        int n;
        n = $urandom_range(0, 6);
        run_pkt(vp[$urandom_range(0, 4)], n,
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 6)) : -1,
                $urandom_range(0, 2), 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
